stream_mux_n: RTL and testbench

//  Parametrised N-input, DATA_W-bit registered stream multiplexer with valid/ready handshake.
//  It is the sequential successor of the combinational 4:1 bit mux.

---
 rtl/stream_pkg.sv | 17 +
 rtl/stream_mux_n_if.sv | 30 +++
 rtl/stream_mux_n_mux_nto1.sv | 20 ++
 rtl/stream_mux_n.sv | 100 ++++++++++
 tb/tb_stream_mux_n.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream multiplexer: FSM state encoding and a
// constant-evaluable clog2 for deriving select widths from channel counts.
package stream_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// The slave modport is the mux view; master is the producer/consumer view.
interface stream_mux_n_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) ();
  localparam int SEL_W = stream_pkg::clog2(N);

  logic [SEL_W-1:0]    sel;
  logic [N*DATA_W-1:0] in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [SEL_W-1:0]    out_chan;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport slave (
    input  sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_chan, out_valid, busy
  );

  modport master (
    output sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_chan, out_valid, busy
  );
endinterface

// File: rtl/stream_mux_n_mux_nto1.sv
// Combinational N:1 select of DATA_W-bit lanes from a flat bus; 0 latency.
// Select values >= N yield all zeros.
module mux_nto1 #(
  parameter int N      = 4,
  parameter int DATA_W = 8
) (
  input  logic [stream_pkg::clog2(N)-1:0] i_sel,
  input  logic [N*DATA_W-1:0]             i_bus,
  output logic [DATA_W-1:0]               o_dat
);
  import stream_pkg::*;
  localparam int SEL_W = clog2(N);

  always_comb begin
    o_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SEL_W'(i)) o_dat = i_bus[i*DATA_W +: DATA_W];
    end
  end
endmodule

// File: rtl/stream_mux_n.sv
// Registered N:1 stream mux with optional packet lock; 1 cycle accept-to-out_valid.
// Backpressure: in_ready follows out_ready combinationally; output register holds on stall.
module stream_mux_n #(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_PKT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  stream_mux_n_if.slave  bus
);
  import stream_pkg::*;
  localparam int SEL_W = clog2(N);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_lock_chan;
  logic [SEL_W-1:0]   w_cur_chan;
  logic               w_chan_ok;
  logic               w_load;
  logic               w_accept;
  logic               w_busy;
  logic [N-1:0]       w_in_ready;
  logic [DATA_W-1:0]  w_data_sel;
  logic               w_last_sel;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_out_last;
  logic [SEL_W-1:0]   r_out_chan;
  logic               r_out_valid;

  assign w_cur_chan = (r_state == ST_LOCKED) ? r_lock_chan : bus.sel;
  assign w_chan_ok  = int'(w_cur_chan) < N;
  assign w_load     = !r_out_valid || bus.out_ready;

  // Grant is one-hot by construction and held low during reset.
  always_comb begin
    w_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_in_ready[i] = rst_n && w_load && w_chan_ok && (w_cur_chan == SEL_W'(i));
    end
  end

  assign w_accept = |(bus.in_valid & w_in_ready);

  mux_nto1 #(.N(N), .DATA_W(DATA_W)) u_mux_data (
    .i_sel (w_cur_chan),
    .i_bus (bus.in_data),
    .o_dat (w_data_sel)
  );

  mux_nto1 #(.N(N), .DATA_W(1)) u_mux_last (
    .i_sel (w_cur_chan),
    .i_bus (bus.in_last),
    .o_dat (w_last_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_chan <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED) r_lock_chan <= bus.sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (LOCK_PKT != 0 && w_accept) w_state_nxt = w_last_sel ? ST_IDLE : ST_LOCKED;
  end

  always_comb begin
    w_busy = (r_state == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_chan  <= '0;
    end else if (w_load) begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_data_sel;
        r_out_last  <= w_last_sel;
        r_out_chan  <= w_cur_chan;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed scenarios plus a randomized run against a
// transaction-level model (grant rule, packet lock, in-order beat queue).
module tb_stream_mux_n;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  stream_mux_n_if #(.N(4), .DATA_W(8)) bus0 ();
  stream_mux_n_if #(.N(3), .DATA_W(8)) bus1 ();
  stream_mux_n_if #(.N(4), .DATA_W(8)) bus2 ();

  stream_mux_n #(.N(4), .DATA_W(8), .LOCK_PKT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  stream_mux_n #(.N(3), .DATA_W(8), .LOCK_PKT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  stream_mux_n #(.N(4), .DATA_W(8), .LOCK_PKT(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus0.in_valid = '0; bus1.in_valid = '0; bus2.in_valid = '0;
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1; bus2.out_ready = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.sel = 2'($urandom); bus0.in_data = $urandom; bus0.in_valid = 4'($urandom);
    bus0.in_last = 4'($urandom); bus0.out_ready = 1'($urandom);
    bus1.sel = 2'd0; bus1.in_data = '0; bus1.in_valid = '0; bus1.in_last = '0; bus1.out_ready = 1'b0;
    bus2.sel = 2'd0; bus2.in_data = '0; bus2.in_valid = '0; bus2.in_last = '0; bus2.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus0.out_valid); end
    tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", bus0.busy); end
    tests++; if (bus0.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got %b exp 0000", bus0.in_ready); end
    tests++; if (bus0.out_data !== 8'h00 || bus0.out_chan !== 2'd0) begin fails++; $display("FAIL reset_out_regs got %h/%0d exp 00/0", bus0.out_data, bus0.out_chan); end
    bus0.sel = 2'd0; bus0.in_valid = '0; bus0.out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++; if (bus0.in_ready !== 4'b0001) begin fails++; $display("FAIL reset_release_ready got %b exp 0001", bus0.in_ready); end
    drain();
  endtask

  task automatic test_single_beat();
    bus0.sel = 2'd2; bus0.in_valid = 4'b0100; bus0.in_last = 4'b0100;
    bus0.in_data = 32'h00A5_0000; bus0.out_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus0.in_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b exp 0100", bus0.in_ready); end
    step();
    bus0.in_valid = '0;
    @(negedge clk);
    tests++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'hA5) begin fails++; $display("FAIL single_data got v=%b %h exp v=1 a5", bus0.out_valid, bus0.out_data); end
    tests++; if (bus0.out_chan !== 2'd2 || bus0.out_last !== 1'b1) begin fails++; $display("FAIL single_chan_last got %0d/%b exp 2/1", bus0.out_chan, bus0.out_last); end
    tests++; if (bus0.busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", bus0.busy); end
    step();
    @(negedge clk);
    tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", bus0.out_valid); end
    drain();
  endtask

  task automatic test_lock();
    bus0.sel = 2'd1; bus0.in_valid = 4'b1010; bus0.in_last = 4'b1000;
    bus0.in_data = 32'h4400_1100; bus0.out_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus0.in_ready !== 4'b0010) begin fails++; $display("FAIL lock_ready0 got %b exp 0010", bus0.in_ready); end
    step();
    bus0.sel = 2'd3; bus0.in_data[15:8] = 8'h22;
    @(negedge clk);
    tests++; if (bus0.busy !== 1'b1 || bus0.in_ready !== 4'b0010) begin fails++; $display("FAIL lock_hold1 got busy=%b rdy=%b exp 1/0010", bus0.busy, bus0.in_ready); end
    tests++; if (bus0.out_data !== 8'h11 || bus0.out_chan !== 2'd1) begin fails++; $display("FAIL lock_beat1 got %h/%0d exp 11/1", bus0.out_data, bus0.out_chan); end
    step();
    bus0.in_data[15:8] = 8'h33; bus0.in_last = 4'b1010;
    @(negedge clk);
    tests++; if (bus0.busy !== 1'b1 || bus0.in_ready !== 4'b0010) begin fails++; $display("FAIL lock_hold2 got busy=%b rdy=%b exp 1/0010", bus0.busy, bus0.in_ready); end
    tests++; if (bus0.out_data !== 8'h22 || bus0.out_chan !== 2'd1) begin fails++; $display("FAIL lock_beat2 got %h/%0d exp 22/1", bus0.out_data, bus0.out_chan); end
    step();
    bus0.in_valid = 4'b1000;
    @(negedge clk);
    tests++; if (bus0.busy !== 1'b0 || bus0.in_ready !== 4'b1000) begin fails++; $display("FAIL lock_release got busy=%b rdy=%b exp 0/1000", bus0.busy, bus0.in_ready); end
    tests++; if (bus0.out_data !== 8'h33 || bus0.out_chan !== 2'd1 || bus0.out_last !== 1'b1) begin fails++; $display("FAIL lock_beat3 got %h/%0d/%b exp 33/1/1", bus0.out_data, bus0.out_chan, bus0.out_last); end
    step();
    bus0.in_valid = '0;
    @(negedge clk);
    tests++; if (bus0.out_data !== 8'h44 || bus0.out_chan !== 2'd3 || bus0.busy !== 1'b0) begin fails++; $display("FAIL lock_next_chan got %h/%0d busy=%b exp 44/3/0", bus0.out_data, bus0.out_chan, bus0.busy); end
    drain();
  endtask

  task automatic test_backpressure();
    bus0.sel = 2'd0; bus0.in_valid = 4'b0001; bus0.in_last = 4'b0001;
    bus0.in_data = 32'h0000_0050; bus0.out_ready = 1'b1;
    step();
    bus0.out_ready = 1'b0; bus0.in_data[7:0] = 8'h51;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h50 || bus0.in_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_stall%0d got v=%b %h rdy=%b exp 1/50/0000", k, bus0.out_valid, bus0.out_data, bus0.in_ready);
      end
      step();
    end
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'(8'h50 + k) || bus0.in_ready !== 4'b0001) begin
        fails++; $display("FAIL bp_flow%0d got v=%b %h rdy=%b exp 1/%h/0001", k, bus0.out_valid, bus0.out_data, bus0.in_ready, 8'(8'h50 + k));
      end
      step();
      bus0.in_data[7:0] = 8'(8'h52 + k);
      bus0.in_valid = (k < 4) ? 4'b0001 : 4'b0000;
    end
    @(negedge clk);
    tests++; if (bus0.out_valid !== 1'b1 || bus0.out_data !== 8'h55) begin fails++; $display("FAIL bp_tail got v=%b %h exp 1/55", bus0.out_valid, bus0.out_data); end
    step();
    @(negedge clk);
    tests++; if (bus0.out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", bus0.out_valid); end
    drain();
  endtask

  task automatic test_invalid_sel();
    bus1.sel = 2'd0; bus1.in_valid = 3'b001; bus1.in_last = 3'b111;
    bus1.in_data = 24'h000077; bus1.out_ready = 1'b1;
    step();
    bus1.sel = 2'd3; bus1.in_valid = 3'b111; bus1.out_ready = 1'b0;
    @(negedge clk);
    tests++; if (bus1.out_valid !== 1'b1 || bus1.in_ready !== 3'b000) begin fails++; $display("FAIL inv_stall got v=%b rdy=%b exp 1/000", bus1.out_valid, bus1.in_ready); end
    step();
    bus1.out_ready = 1'b1;
    @(negedge clk);
    tests++; if (bus1.in_ready !== 3'b000 || bus1.out_data !== 8'h77) begin fails++; $display("FAIL inv_ready got rdy=%b %h exp 000/77", bus1.in_ready, bus1.out_data); end
    step();
    @(negedge clk);
    tests++; if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0 || bus1.in_ready !== 3'b000) begin
      fails++; $display("FAIL inv_drain got v=%b busy=%b rdy=%b exp 0/0/000", bus1.out_valid, bus1.busy, bus1.in_ready);
    end
    drain();
  endtask

  task automatic test_no_lock();
    int cnt[2];
    logic [7:0] exp_d;
    int exp_c;
    cnt[0] = 0; cnt[1] = 0; exp_d = '0; exp_c = 0;
    bus2.in_valid = 4'b0011; bus2.in_last = 4'b0000; bus2.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int c;
      c = k % 2;
      bus2.sel = 2'(c);
      bus2.in_data[7:0]  = {4'h0, 4'(cnt[0])};
      bus2.in_data[15:8] = {4'h1, 4'(cnt[1])};
      @(negedge clk);
      tests++; if (bus2.busy !== 1'b0 || bus2.in_ready !== 4'(1 << c)) begin fails++; $display("FAIL nolock_ready%0d got busy=%b rdy=%b exp 0/%b", k, bus2.busy, bus2.in_ready, 4'(1 << c)); end
      if (k > 0) begin
        tests++; if (bus2.out_valid !== 1'b1 || bus2.out_chan !== 2'(exp_c) || bus2.out_data !== exp_d) begin
          fails++; $display("FAIL nolock_beat%0d got v=%b %0d/%h exp 1/%0d/%h", k, bus2.out_valid, bus2.out_chan, bus2.out_data, exp_c, exp_d);
        end
      end
      exp_d = {4'(c), 4'(cnt[c])};
      exp_c = c;
      cnt[c]++;
      step();
    end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    bus0.sel = 2'd1; bus0.in_valid = 4'b0010; bus0.in_last = 4'b0000;
    bus0.in_data = 32'h0000_9900; bus0.out_ready = 1'b1;
    step();
    bus0.in_valid = 4'b0100; bus0.sel = 2'd2;
    @(negedge clk);
    tests++; if (bus0.busy !== 1'b1) begin fails++; $display("FAIL midrst_locked got %b exp 1", bus0.busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b0 || bus0.in_ready !== 4'b0000) begin
      fails++; $display("FAIL midrst_asserted got v=%b busy=%b rdy=%b exp 0/0/0000", bus0.out_valid, bus0.busy, bus0.in_ready);
    end
    #2;
    rst_n = 1'b1;
    #1;
    tests++; if (bus0.in_ready !== 4'b0100 || bus0.busy !== 1'b0) begin fails++; $display("FAIL midrst_release got rdy=%b busy=%b exp 0100/0", bus0.in_ready, bus0.busy); end
    bus0.in_valid = '0;
    drain();
  endtask

  task automatic test_random();
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_chan[$];
    logic [3:0] pend;
    logic [7:0] pdat[4];
    logic       plast[4];
    int         cnt[4];
    int         lock;
    pend = '0; lock = -1;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; pdat[i] = '0; plast[i] = 1'b0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int cur;
      logic load;
      logic [3:0] exp_rdy;
      bus0.sel = 2'($urandom_range(0, 3));
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pdat[i] = {i[1:0], 6'(cnt[i])};
          plast[i] = ($urandom_range(0, 2) == 0);
        end
        bus0.in_data[i*8 +: 8] = pdat[i];
        bus0.in_last[i] = plast[i];
      end
      bus0.in_valid = pend;
      @(negedge clk);
      cur = (lock >= 0) ? lock : int'(bus0.sel);
      load = (q_data.size() == 0) || bus0.out_ready;
      exp_rdy = load ? 4'(1 << cur) : 4'b0000;
      tests++; if (bus0.in_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, bus0.in_ready, exp_rdy); end
      tests++; if (bus0.busy !== (lock >= 0)) begin fails++; $display("FAIL rnd_busy c%0d got %b exp %b", cyc, bus0.busy, lock >= 0); end
      tests++; if (bus0.out_valid !== (q_data.size() != 0)) begin fails++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, bus0.out_valid, q_data.size() != 0); end
      if (q_data.size() != 0) begin
        tests++; if (bus0.out_data !== q_data[0] || bus0.out_last !== q_last[0] || bus0.out_chan !== 2'(q_chan[0])) begin
          fails++; $display("FAIL rnd_beat c%0d got %h/%b/%0d exp %h/%b/%0d", cyc, bus0.out_data, bus0.out_last, bus0.out_chan, q_data[0], q_last[0], q_chan[0]);
        end
        if (bus0.out_ready) begin
          void'(q_data.pop_front()); void'(q_last.pop_front()); void'(q_chan.pop_front());
        end
      end
      if (load && pend[cur]) begin
        q_data.push_back(pdat[cur]); q_last.push_back(plast[cur]); q_chan.push_back(cur);
        pend[cur] = 1'b0;
        cnt[cur]++;
        lock = plast[cur] ? -1 : cur;
      end
      step();
    end
    drain();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_beat();
    test_lock();
    test_backpressure();
    test_invalid_sel();
    test_no_lock();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
